// File: rtl/buyruk_getir_kuyrugu_if.sv
// Fetch-stage bundle: cache address/data/wait, redirect request and decode-side FIFO head.
// master = fetch unit, slave = surrounding cache/decode/branch logic.
interface buyruk_getir_kuyrugu_if;
   logic [17:0] l1b_adres_o;
   logic        l1b_bekle_i;
   logic [31:0] l1b_deger_i;
   logic        dallan_gecerli_i;
   logic [17:0] dallan_adres_i;
   logic        cikis_gecerli_o;
   logic        cikis_hazir_i;
   logic [31:0] cikis_buyruk_o;
   logic [17:0] cikis_pc_o;
   logic        cikis_sikistirilmis_o;

   modport master (
      output l1b_adres_o,
      input  l1b_bekle_i,
      input  l1b_deger_i,
      input  dallan_gecerli_i,
      input  dallan_adres_i,
      output cikis_gecerli_o,
      input  cikis_hazir_i,
      output cikis_buyruk_o,
      output cikis_pc_o,
      output cikis_sikistirilmis_o
   );

   modport slave (
      input  l1b_adres_o,
      output l1b_bekle_i,
      output l1b_deger_i,
      output dallan_gecerli_i,
      output dallan_adres_i,
      input  cikis_gecerli_o,
      output cikis_hazir_i,
      input  cikis_buyruk_o,
      input  cikis_pc_o,
      input  cikis_sikistirilmis_o
   );
endinterface

// File: rtl/buyruk_getir_kuyrugu.sv
// Fetch stage: halfword PC to L1I, RV32C length decode, DEPTH-entry queue to decode; hit->valid 1 cycle.
// Full queue stalls fetch (no ready->cache path); redirects flush, and a redirect during a miss waits for the refill.
module buyruk_getir_kuyrugu #(
   parameter int          DEPTH    = 4,
   parameter logic [17:0] RESET_PC = 18'h0
) (
   input logic                    clk_i,
   input logic                    rst_ni,
   buyruk_getir_kuyrugu_if.master bus
);
   localparam int          AW        = $clog2(DEPTH);
   localparam logic [AW:0] DOLU_SAYI = (AW + 1)'(DEPTH);

   localparam logic [0:0] NORMAL   = 1'b0;
   localparam logic [0:0] BEKLEYEN = 1'b1;

   logic [0:0]    state_q;
   logic [17:0]   pc_q;
   logic [17:0]   hedef_q;
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;

   logic [17:0] pc_mem     [DEPTH];
   logic [31:0] buyruk_mem [DEPTH];
   logic        c_mem      [DEPTH];

   logic        bos;
   logic        dolu;
   logic        sikis;
   logic [31:0] genis;
   logic        gecerli;
   logic        push;
   logic        pop;

   assign bos   = (count_q == '0);
   assign dolu  = (count_q == DOLU_SAYI);
   assign sikis = (bus.l1b_deger_i[1:0] != 2'b11);
   assign genis = sikis ? {16'h0, bus.l1b_deger_i[15:0]} : bus.l1b_deger_i;

   // A redirect hides the head in the same cycle so decode never consumes a wrong-path entry.
   assign gecerli = (state_q == NORMAL) && !bos && !bus.dallan_gecerli_i;
   assign push    = (state_q == NORMAL) && !bus.dallan_gecerli_i && !bus.l1b_bekle_i && !dolu;
   assign pop     = gecerli && bus.cikis_hazir_i;

   assign bus.l1b_adres_o           = pc_q;
   assign bus.cikis_gecerli_o       = gecerli;
   assign bus.cikis_buyruk_o        = bos ? 32'h0 : buyruk_mem[rd_ptr_q];
   assign bus.cikis_pc_o            = bos ? 18'h0 : pc_mem[rd_ptr_q];
   assign bus.cikis_sikistirilmis_o = bos ? 1'b0  : c_mem[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= NORMAL;
         pc_q    <= RESET_PC;
         hedef_q <= 18'h0;
      end else begin
         case (state_q)
            NORMAL: begin
               if (bus.dallan_gecerli_i) begin
                  // During a miss the address must stay put until the refill lands.
                  if (bus.l1b_bekle_i) begin
                     hedef_q <= bus.dallan_adres_i;
                     state_q <= BEKLEYEN;
                  end else begin
                     pc_q <= bus.dallan_adres_i;
                  end
               end else if (push) begin
                  pc_q <= pc_q + (sikis ? 18'd1 : 18'd2);
               end
            end
            BEKLEYEN: begin
               if (bus.dallan_gecerli_i) begin
                  if (bus.l1b_bekle_i) begin
                     hedef_q <= bus.dallan_adres_i;
                  end else begin
                     pc_q    <= bus.dallan_adres_i;
                     state_q <= NORMAL;
                  end
               end else if (!bus.l1b_bekle_i) begin
                  pc_q    <= hedef_q;
                  state_q <= NORMAL;
               end
            end
            default: state_q <= NORMAL;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (bus.dallan_gecerli_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem[wr_ptr_q]     <= pc_q;
         buyruk_mem[wr_ptr_q] <= genis;
         c_mem[wr_ptr_q]      <= sikis;
      end
   end
endmodule

// File: tb/tb_buyruk_getir_kuyrugu.sv
// Bench for buyruk_getir_kuyrugu: directed scenarios plus randomized traffic against a queue-based model.
module tb_buyruk_getir_kuyrugu;
   localparam int DEPTH = 4;

   typedef struct {
      logic [17:0] pc;
      logic [31:0] w;
      logic        c;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   buyruk_getir_kuyrugu_if bus();

   buyruk_getir_kuyrugu #(.DEPTH(DEPTH), .RESET_PC(18'h0)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   ent_t        q[$];
   logic [17:0] m_pc;
   logic [17:0] m_hedef;
   bit          m_pend;
   logic [17:0] exp_adres;
   logic        exp_gec;
   ent_t        exp_head;
   int          n_cmp = 0;
   int          n_fail = 0;

   task automatic reset_model();
      q.delete();
      m_pc    = 18'h0;
      m_hedef = 18'h0;
      m_pend  = 0;
   endtask

   task automatic apply(input logic bekle, input logic [31:0] deger, input logic dallan,
                        input logic [17:0] adres, input logic hazir);
      @(negedge clk);
      bus.l1b_bekle_i      = bekle;
      bus.l1b_deger_i      = deger;
      bus.dallan_gecerli_i = dallan;
      bus.dallan_adres_i   = adres;
      bus.cikis_hazir_i    = hazir;
      #1;
      exp_adres = m_pc;
      exp_gec   = !m_pend && (q.size() != 0) && !dallan;
      if (q.size() != 0) exp_head = q[0];
   endtask

   // Model update for the posedge following apply(), from the stimulus the bench itself drove.
   task automatic advance();
      ent_t        e;
      logic [31:0] d;
      bit          do_push;
      bit          do_pop;
      d = bus.l1b_deger_i;
      if (m_pend) begin
         if (bus.dallan_gecerli_i) begin
            if (bus.l1b_bekle_i) m_hedef = bus.dallan_adres_i;
            else begin m_pc = bus.dallan_adres_i; m_pend = 0; end
         end else if (!bus.l1b_bekle_i) begin
            m_pc = m_hedef;
            m_pend = 0;
         end
      end else if (bus.dallan_gecerli_i) begin
         q.delete();
         if (bus.l1b_bekle_i) begin m_pend = 1; m_hedef = bus.dallan_adres_i; end
         else m_pc = bus.dallan_adres_i;
      end else begin
         do_pop  = exp_gec && bus.cikis_hazir_i;
         do_push = !bus.l1b_bekle_i && (q.size() < DEPTH);
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            e.pc = m_pc;
            e.c  = (d % 4) != 3;
            e.w  = e.c ? (d % 65536) : d;
            q.push_back(e);
            m_pc = 18'((32'(m_pc) + (e.c ? 1 : 2)) % 262144);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.l1b_bekle_i = 1'b1; bus.l1b_deger_i = 32'h0; bus.dallan_gecerli_i = 1'b0;
      bus.dallan_adres_i = 18'h0; bus.cikis_hazir_i = 1'b0;
      reset_model();
      #12;
      n_cmp++; if (bus.l1b_adres_o !== 18'h0) begin n_fail++; $display("FAIL reset_adres got %h want 0", bus.l1b_adres_o); end
      n_cmp++; if (bus.cikis_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL reset_gecerli got %b want 0", bus.cikis_gecerli_o); end
      n_cmp++; if (bus.cikis_buyruk_o !== 32'h0) begin n_fail++; $display("FAIL reset_buyruk got %h want 0", bus.cikis_buyruk_o); end
      n_cmp++; if (bus.cikis_pc_o !== 18'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", bus.cikis_pc_o); end
      n_cmp++; if (bus.cikis_sikistirilmis_o !== 1'b0) begin n_fail++; $display("FAIL reset_c got %b want 0", bus.cikis_sikistirilmis_o); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_hits_32bit();
      for (int k = 0; k < 6; k++) begin
         apply(1'b0, 32'h00000013, 1'b0, 18'h0, 1'b1);
         n_cmp++; if (bus.l1b_adres_o !== 18'(2 * k)) begin n_fail++; $display("FAIL hit_adres[%0d] got %h want %h", k, bus.l1b_adres_o, 18'(2 * k)); end
         n_cmp++; if (bus.cikis_gecerli_o !== (k != 0)) begin n_fail++; $display("FAIL hit_gecerli[%0d] got %b want %b", k, bus.cikis_gecerli_o, k != 0); end
         if (k != 0) begin
            n_cmp++; if (bus.cikis_pc_o !== 18'(2 * (k - 1))) begin n_fail++; $display("FAIL hit_pc[%0d] got %h want %h", k, bus.cikis_pc_o, 18'(2 * (k - 1))); end
            n_cmp++; if (bus.cikis_sikistirilmis_o !== 1'b0 || bus.cikis_buyruk_o !== 32'h13) begin n_fail++; $display("FAIL hit_data[%0d] got %h/%b want 00000013/0", k, bus.cikis_buyruk_o, bus.cikis_sikistirilmis_o); end
         end
         advance();
      end
   endtask

   task automatic test_compressed();
      apply(1'b0, 32'h0, 1'b1, 18'h0, 1'b1);
      advance();
      apply(1'b0, 32'h00014501, 1'b0, 18'h0, 1'b1);
      n_cmp++; if (bus.l1b_adres_o !== 18'h0) begin n_fail++; $display("FAIL c_adres0 got %h want 0", bus.l1b_adres_o); end
      advance();
      apply(1'b1, 32'h0, 1'b0, 18'h0, 1'b0);
      n_cmp++; if (bus.l1b_adres_o !== 18'h1) begin n_fail++; $display("FAIL c_adres1 got %h want 1", bus.l1b_adres_o); end
      n_cmp++; if (bus.cikis_gecerli_o !== 1'b1) begin n_fail++; $display("FAIL c_gecerli got %b want 1", bus.cikis_gecerli_o); end
      n_cmp++; if (bus.cikis_buyruk_o !== 32'h00004501) begin n_fail++; $display("FAIL c_buyruk got %h want 00004501", bus.cikis_buyruk_o); end
      n_cmp++; if (bus.cikis_sikistirilmis_o !== 1'b1 || bus.cikis_pc_o !== 18'h0) begin n_fail++; $display("FAIL c_flag_pc got %b/%h want 1/0", bus.cikis_sikistirilmis_o, bus.cikis_pc_o); end
      advance();
   endtask

   task automatic test_full();
      apply(1'b0, 32'h0, 1'b1, 18'h10, 1'b0);
      advance();
      for (int k = 0; k < 8; k++) begin
         apply(1'b0, 32'h00000013, 1'b0, 18'h0, 1'b0);
         n_cmp++; if (bus.l1b_adres_o !== exp_adres) begin n_fail++; $display("FAIL full_adres[%0d] got %h want %h", k, bus.l1b_adres_o, exp_adres); end
         advance();
      end
      apply(1'b0, 32'h00000013, 1'b0, 18'h0, 1'b0);
      n_cmp++; if (bus.l1b_adres_o !== 18'h18) begin n_fail++; $display("FAIL full_frozen got %h want 00018", bus.l1b_adres_o); end
      n_cmp++; if (bus.cikis_pc_o !== 18'h10) begin n_fail++; $display("FAIL full_head got %h want 00010", bus.cikis_pc_o); end
      advance();
      for (int k = 0; k < 12; k++) begin
         apply(1'b0, $urandom, 1'b0, 18'h0, 1'b1);
         n_cmp++; if (bus.l1b_adres_o !== exp_adres) begin n_fail++; $display("FAIL drain_adres[%0d] got %h want %h", k, bus.l1b_adres_o, exp_adres); end
         n_cmp++; if (bus.cikis_gecerli_o !== exp_gec) begin n_fail++; $display("FAIL drain_gecerli[%0d] got %b want %b", k, bus.cikis_gecerli_o, exp_gec); end
         if (exp_gec) begin
            n_cmp++; if (bus.cikis_pc_o !== exp_head.pc || bus.cikis_buyruk_o !== exp_head.w) begin n_fail++; $display("FAIL drain_head[%0d] got %h/%h want %h/%h", k, bus.cikis_pc_o, bus.cikis_buyruk_o, exp_head.pc, exp_head.w); end
         end
         advance();
      end
   endtask

   task automatic test_redirect_normal();
      apply(1'b0, 32'h0, 1'b1, 18'h0, 1'b0);
      advance();
      for (int k = 0; k < 3; k++) begin
         apply(1'b0, 32'h00000013, 1'b0, 18'h0, 1'b0);
         advance();
      end
      apply(1'b0, 32'h00000013, 1'b1, 18'h100, 1'b1);
      n_cmp++; if (bus.cikis_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL rd_gecerli_same got %b want 0", bus.cikis_gecerli_o); end
      advance();
      apply(1'b1, 32'h0, 1'b0, 18'h0, 1'b1);
      n_cmp++; if (bus.cikis_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL rd_gecerli_next got %b want 0", bus.cikis_gecerli_o); end
      n_cmp++; if (bus.l1b_adres_o !== 18'h100) begin n_fail++; $display("FAIL rd_adres got %h want 00100", bus.l1b_adres_o); end
      advance();
   endtask

   task automatic test_redirect_miss();
      apply(1'b0, 32'h0, 1'b1, 18'h30, 1'b0);
      advance();
      for (int k = 0; k < 2; k++) begin
         apply(1'b0, 32'h00000013, 1'b0, 18'h0, 1'b0);
         advance();
      end
      apply(1'b1, 32'h0, 1'b1, 18'h200, 1'b1);
      n_cmp++; if (bus.l1b_adres_o !== 18'h34) begin n_fail++; $display("FAIL miss_adres_pre got %h want 00034", bus.l1b_adres_o); end
      advance();
      for (int k = 0; k < 4; k++) begin
         apply(1'b1, 32'h0, 1'b0, 18'h0, 1'b1);
         n_cmp++; if (bus.l1b_adres_o !== 18'h34) begin n_fail++; $display("FAIL miss_adres_hold[%0d] got %h want 00034", k, bus.l1b_adres_o); end
         n_cmp++; if (bus.cikis_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL miss_gecerli[%0d] got %b want 0", k, bus.cikis_gecerli_o); end
         advance();
      end
      apply(1'b0, 32'h00000013, 1'b0, 18'h0, 1'b1);
      n_cmp++; if (bus.l1b_adres_o !== 18'h34) begin n_fail++; $display("FAIL miss_adres_ret got %h want 00034", bus.l1b_adres_o); end
      advance();
      apply(1'b1, 32'h0, 1'b0, 18'h0, 1'b1);
      n_cmp++; if (bus.l1b_adres_o !== 18'h200) begin n_fail++; $display("FAIL miss_adres_tgt got %h want 00200", bus.l1b_adres_o); end
      n_cmp++; if (bus.cikis_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL miss_dropped got %b want 0", bus.cikis_gecerli_o); end
      advance();
      apply(1'b0, 32'h00000013, 1'b0, 18'h0, 1'b0);
      advance();
      apply(1'b1, 32'h0, 1'b0, 18'h0, 1'b1);
      n_cmp++; if (bus.cikis_gecerli_o !== 1'b1 || bus.cikis_pc_o !== 18'h200) begin n_fail++; $display("FAIL miss_first got %b/%h want 1/00200", bus.cikis_gecerli_o, bus.cikis_pc_o); end
      advance();
   endtask

   task automatic test_wrap();
      apply(1'b0, 32'h0, 1'b1, 18'h3FFFF, 1'b1);
      advance();
      apply(1'b0, 32'h00000013, 1'b0, 18'h0, 1'b1);
      advance();
      apply(1'b1, 32'h0, 1'b0, 18'h0, 1'b0);
      n_cmp++; if (bus.l1b_adres_o !== 18'h1) begin n_fail++; $display("FAIL wrap_adres got %h want 00001", bus.l1b_adres_o); end
      n_cmp++; if (bus.cikis_pc_o !== 18'h3FFFF) begin n_fail++; $display("FAIL wrap_head got %h want 3ffff", bus.cikis_pc_o); end
      advance();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         apply(($urandom % 3) == 0, $urandom, ($urandom % 12) == 0,
               18'($urandom_range(0, 262143)), ($urandom % 4) != 0);
         n_cmp++; if (bus.l1b_adres_o !== exp_adres) begin n_fail++; $display("FAIL rnd_adres[%0d] got %h want %h", k, bus.l1b_adres_o, exp_adres); end
         n_cmp++; if (bus.cikis_gecerli_o !== exp_gec) begin n_fail++; $display("FAIL rnd_gecerli[%0d] got %b want %b", k, bus.cikis_gecerli_o, exp_gec); end
         if (exp_gec) begin
            n_cmp++;
            if (bus.cikis_pc_o !== exp_head.pc || bus.cikis_buyruk_o !== exp_head.w ||
                bus.cikis_sikistirilmis_o !== exp_head.c) begin
               n_fail++;
               $display("FAIL rnd_head[%0d] got %h/%h/%b want %h/%h/%b", k, bus.cikis_pc_o, bus.cikis_buyruk_o,
                        bus.cikis_sikistirilmis_o, exp_head.pc, exp_head.w, exp_head.c);
            end
         end
         advance();
      end
   endtask

   task automatic test_async_reset();
      apply(1'b0, 32'h0, 1'b1, 18'h55, 1'b0);
      advance();
      for (int k = 0; k < 2; k++) begin
         apply(1'b0, 32'h00000013, 1'b0, 18'h0, 1'b0);
         advance();
      end
      apply(1'b1, 32'h0, 1'b0, 18'h0, 1'b0);
      n_cmp++; if (bus.cikis_gecerli_o !== 1'b1 || bus.l1b_adres_o !== 18'h59) begin n_fail++; $display("FAIL ar_pre got %b/%h want 1/00059", bus.cikis_gecerli_o, bus.l1b_adres_o); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.l1b_adres_o !== 18'h0) begin n_fail++; $display("FAIL ar_adres got %h want 0", bus.l1b_adres_o); end
      n_cmp++; if (bus.cikis_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL ar_gecerli got %b want 0", bus.cikis_gecerli_o); end
      n_cmp++; if (bus.cikis_buyruk_o !== 32'h0 || bus.cikis_pc_o !== 18'h0 || bus.cikis_sikistirilmis_o !== 1'b0) begin n_fail++; $display("FAIL ar_head got %h/%h/%b want 0/0/0", bus.cikis_buyruk_o, bus.cikis_pc_o, bus.cikis_sikistirilmis_o); end
      reset_model();
      @(negedge clk);
      rst_n = 1'b1;
      apply(1'b0, 32'h00000013, 1'b0, 18'h0, 1'b1);
      n_cmp++; if (bus.l1b_adres_o !== 18'h0) begin n_fail++; $display("FAIL ar_restart got %h want 0", bus.l1b_adres_o); end
      advance();
   endtask

   initial begin
      test_reset();
      test_hits_32bit();
      test_compressed();
      test_full();
      test_redirect_normal();
      test_redirect_miss();
      test_wrap();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
